// File: rtl/llc_pkg.sv
// Shared types and default geometry for the last-level cache model.
package llc_pkg;

  localparam int unsigned DEF_ADDR_BITS   = 32;
  localparam int unsigned DEF_CMDSIZE     = 4;
  localparam int unsigned DEF_OFFSET_BITS = 6;
  localparam int unsigned DEF_INDEX_BITS  = 14;
  localparam int unsigned DEF_WAYS        = 8;
  localparam int unsigned DEF_TAG_BITS    = DEF_ADDR_BITS - DEF_INDEX_BITS - DEF_OFFSET_BITS;

  typedef enum logic [3:0] {
    CMD_READ      = 4'd0,
    CMD_WRITE     = 4'd1,
    CMD_IFETCH    = 4'd2,
    CMD_SNP_READ  = 4'd3,
    CMD_SNP_WRITE = 4'd4,
    CMD_SNP_RWIM  = 4'd5,
    CMD_SNP_INV   = 4'd6,
    CMD_CLEAR     = 4'd8,
    CMD_PRINT     = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_READ  = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_INVAL = 3'd3,
    BUS_RWIM  = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_t;

  // Other caches' answer to our own bus read, encoded in the low address bits
  function automatic snoop_t own_snoop(input logic [1:0] lsb);
    case (lsb)
      2'b00:   return SNP_HIT;
      2'b01:   return SNP_HITM;
      default: return SNP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/llc_cache_if.sv
// Trace-command bus between the trace front end and the cache model.
interface llc_cache_if
  import llc_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned CMDSIZE   = DEF_CMDSIZE
);
  logic                 eof;
  logic [CMDSIZE-1:0]   command;
  logic [ADDR_BITS-1:0] address;
  logic                 mode;
  logic [31:0]          reads;
  logic [31:0]          writes;
  logic [31:0]          cache_hits;
  logic [31:0]          cache_misses;
  logic [2:0]           bus_op;
  logic                 evict_wb;
  logic [1:0]           snoop_resp;
  logic                 msg_valid;

  modport master (
    output eof, command, address, mode,
    input  reads, writes, cache_hits, cache_misses,
    input  bus_op, evict_wb, snoop_resp, msg_valid
  );

  modport slave (
    input  eof, command, address, mode,
    output reads, writes, cache_hits, cache_misses,
    output bus_op, evict_wb, snoop_resp, msg_valid
  );
endinterface

// File: rtl/llc_plru.sv
// Tree pseudo-LRU for one set: victim select and post-access tree update.
module llc_plru #(
  parameter int unsigned WAYS = 8
) (
  input  logic [WAYS-2:0]         tree,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         tree_next
);
  localparam int unsigned LW = $clog2(WAYS);
  localparam int unsigned NB = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  // Nodes are heap-ordered: children of node n are 2n+1 (lower) and 2n+2 (upper)
  int unsigned   vnode;
  int unsigned   unode;
  logic          vbit;
  logic          ubit;
  logic [LW-1:0] upath;

  // Victim: follow node bits from the root, 0 selects the lower half
  always_comb begin
    victim = '0;
    vnode  = 0;
    vbit   = 1'b0;
    for (int unsigned lvl = 0; lvl < LW; lvl++) begin
      vbit   = tree[NB'(vnode)];
      victim = (victim << 1) | LW'(vbit);
      vnode  = 2 * vnode + 1 + 32'(vbit);
    end
  end

  // Update: every node on the accessed way's path points to the other half
  always_comb begin
    tree_next = tree;
    unode     = 0;
    ubit      = 1'b0;
    upath     = way;
    for (int unsigned lvl = 0; lvl < LW; lvl++) begin
      ubit                   = upath[LW-1];
      upath                  = upath << 1;
      tree_next[NB'(unode)]  = ~ubit;
      unode                  = 2 * unode + 1 + 32'(ubit);
    end
  end

endmodule

// File: rtl/llc_cache.sv
// Set-associative, write-allocate, MESI last-level cache model, one trace command per clock.
module llc_cache
  import llc_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
  parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int unsigned INDEX_BITS  = DEF_INDEX_BITS,
  parameter int unsigned WAYS        = DEF_WAYS
) (
  input logic        clk,
  input logic        rst,
  llc_cache_if.slave bus
);
  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS     = 2 ** INDEX_BITS;
  localparam int unsigned WB       = $clog2(WAYS);

  // Tags are only meaningful while the matching line state is not Invalid
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  mesi_t               st_mem   [SETS][WAYS];
  logic [WAYS-2:0]     plru_mem [SETS];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [WB-1:0]         hit_way;
  logic                  inv_found;
  logic [WB-1:0]         inv_way;
  logic [WB-1:0]         plru_victim;
  logic [WB-1:0]         fill_way;
  logic [WB-1:0]         acc_way;
  logic [WAYS-2:0]       plru_next;
  mesi_t                 hit_st;
  mesi_t                 victim_st;

  bus_op_t       n_bus;
  logic          n_wb;
  snoop_t        n_snp;
  logic          n_mv;
  logic          st_we;
  logic [WB-1:0] st_way;
  mesi_t         st_new;
  logic          tag_we;
  logic          plru_we;
  logic          clear;
  logic          inc_r;
  logic          inc_w;
  logic          inc_h;
  logic          inc_m;
  logic          unused_low_addr;

  assign idx = bus.address[OFFSET_BITS +: INDEX_BITS];
  assign tag = bus.address[ADDR_BITS-1 -: TAG_BITS];
  // Only the two lowest offset bits carry meaning (own snoop result)
  assign unused_low_addr = ^bus.address[OFFSET_BITS-1:2];

  // Lookup: matching valid way, and lowest-numbered Invalid way for fills
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && st_mem[idx][WB'(w)] != MESI_I && tag_mem[idx][WB'(w)] == tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!inv_found && st_mem[idx][WB'(w)] == MESI_I) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
  end

  assign fill_way  = inv_found ? inv_way : plru_victim;
  assign acc_way   = hit ? hit_way : fill_way;
  assign hit_st    = st_mem[idx][hit_way];
  assign victim_st = st_mem[idx][fill_way];

  llc_plru #(.WAYS(WAYS)) u_plru (
    .tree      (plru_mem[idx]),
    .way       (acc_way),
    .victim    (plru_victim),
    .tree_next (plru_next)
  );

  // Command decode: line-state, PLRU and counter effects plus the bus report
  always_comb begin
    n_bus   = BUS_NONE;
    n_wb    = 1'b0;
    n_snp   = SNP_NOHIT;
    n_mv    = 1'b0;
    st_we   = 1'b0;
    st_way  = hit_way;
    st_new  = MESI_I;
    tag_we  = 1'b0;
    plru_we = 1'b0;
    clear   = 1'b0;
    inc_r   = 1'b0;
    inc_w   = 1'b0;
    inc_h   = 1'b0;
    inc_m   = 1'b0;
    if (bus.eof) begin
      case (bus.command)
        CMD_READ, CMD_IFETCH: begin
          n_mv    = !bus.mode;
          inc_r   = 1'b1;
          plru_we = 1'b1;
          if (hit) begin
            inc_h = 1'b1;
          end else begin
            inc_m  = 1'b1;
            n_bus  = BUS_READ;
            n_wb   = (victim_st == MESI_M);
            st_we  = 1'b1;
            st_way = fill_way;
            st_new = (own_snoop(bus.address[1:0]) != SNP_NOHIT) ? MESI_S : MESI_E;
            tag_we = 1'b1;
          end
        end
        CMD_WRITE: begin
          n_mv    = !bus.mode;
          inc_w   = 1'b1;
          plru_we = 1'b1;
          st_we   = 1'b1;
          st_new  = MESI_M;
          if (hit) begin
            inc_h = 1'b1;
            if (hit_st == MESI_S) n_bus = BUS_INVAL;
          end else begin
            inc_m  = 1'b1;
            n_bus  = BUS_RWIM;
            n_wb   = (victim_st == MESI_M);
            st_way = fill_way;
            tag_we = 1'b1;
          end
        end
        CMD_SNP_READ: begin
          n_mv = !bus.mode;
          if (hit) begin
            st_we  = 1'b1;
            st_new = MESI_S;
            if (hit_st == MESI_M) begin
              n_snp = SNP_HITM;
              n_bus = BUS_WRITE;
            end else begin
              n_snp = SNP_HIT;
            end
          end
        end
        CMD_SNP_WRITE: n_mv = !bus.mode;
        CMD_SNP_RWIM: begin
          n_mv = !bus.mode;
          if (hit) begin
            st_we  = 1'b1;
            st_new = MESI_I;
            if (hit_st == MESI_M) begin
              n_snp = SNP_HITM;
              n_bus = BUS_WRITE;
            end else begin
              n_snp = SNP_HIT;
            end
          end
        end
        CMD_SNP_INV: begin
          n_mv = !bus.mode;
          if (hit && hit_st == MESI_S) begin
            n_snp  = SNP_HIT;
            st_we  = 1'b1;
            st_new = MESI_I;
          end
        end
        CMD_CLEAR: clear = 1'b1;
        default: ;
      endcase
    end
  end

  // Tag array has no reset; a line's state alone decides whether it is valid
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[idx][st_way] <= tag;
  end

  // Line states and PLRU trees; reset and clear both empty the whole cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru_mem[INDEX_BITS'(s)] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) st_mem[INDEX_BITS'(s)][WB'(w)] <= MESI_I;
      end
    end else if (clear) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru_mem[INDEX_BITS'(s)] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) st_mem[INDEX_BITS'(s)][WB'(w)] <= MESI_I;
      end
    end else begin
      if (st_we)   st_mem[idx][st_way] <= st_new;
      if (plru_we) plru_mem[idx]       <= plru_next;
    end
  end

  // Statistics and per-command report, registered at the consuming edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reads        <= '0;
      bus.writes       <= '0;
      bus.cache_hits   <= '0;
      bus.cache_misses <= '0;
      bus.bus_op       <= '0;
      bus.evict_wb     <= 1'b0;
      bus.snoop_resp   <= '0;
      bus.msg_valid    <= 1'b0;
    end else if (clear) begin
      bus.reads        <= '0;
      bus.writes       <= '0;
      bus.cache_hits   <= '0;
      bus.cache_misses <= '0;
      bus.bus_op       <= '0;
      bus.evict_wb     <= 1'b0;
      bus.snoop_resp   <= '0;
      bus.msg_valid    <= 1'b0;
    end else begin
      bus.reads        <= bus.reads + 32'(inc_r);
      bus.writes       <= bus.writes + 32'(inc_w);
      bus.cache_hits   <= bus.cache_hits + 32'(inc_h);
      bus.cache_misses <= bus.cache_misses + 32'(inc_m);
      bus.bus_op       <= n_bus;
      bus.evict_wb     <= n_wb;
      bus.snoop_resp   <= n_snp;
      bus.msg_valid    <= n_mv;
    end
  end

endmodule

// File: tb/tb_llc_cache.sv
// Self-checking bench for llc_cache: directed trace plus randomized commands vs. a line-level model.
module tb_llc_cache;
  logic clk = 1'b0;
  logic rst;

  llc_cache_if bus_if ();

  llc_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected outputs after the next consuming edge
  logic [31:0] e_reads, e_writes, e_hits, e_misses;
  logic [2:0]  e_bus;
  logic        e_wb;
  logic [1:0]  e_snp;
  logic        e_mv;

  // Model: 4 tracked sets; state 0=I 1=S 2=E 3=M; PLRU as heap of node bits
  int m_st  [4][8];
  int m_tag [4][8];
  int m_pl  [4][7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int slot_of(input int idx);
    case (idx)
      0:       return 0;
      5:       return 1;
      77:      return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int idx_of(input int slot);
    case (slot)
      0:       return 0;
      1:       return 5;
      2:       return 77;
      default: return 16383;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int t, input int idx, input int lo);
    return (32'(t) << 20) | (32'(idx) << 6) | 32'(lo);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 8; w++) begin
        m_st[s][w]  = 0;
        m_tag[s][w] = 0;
      end
      for (int n = 0; n < 7; n++) m_pl[s][n] = 0;
    end
  endtask

  function automatic int pick_victim(input int s);
    int n;
    for (int w = 0; w < 8; w++) if (m_st[s][w] == 0) return w;
    n = 0;
    for (int l = 0; l < 3; l++) n = 2 * n + 1 + m_pl[s][n];
    return n - 7;
  endfunction

  task automatic touch(input int s, input int w);
    int n, b;
    n = 0;
    for (int l = 0; l < 3; l++) begin
      b = (w >> (2 - l)) & 1;
      m_pl[s][n] = 1 - b;
      n = 2 * n + 1 + b;
    end
  endtask

  task automatic model_step(input logic e, input logic [3:0] c, input logic [31:0] a, input logic md);
    int s, tg, w, hw;
    bit h;
    e_bus = 3'd0;
    e_wb  = 1'b0;
    e_snp = 2'd0;
    e_mv  = 1'b0;
    if (!e) return;
    s  = slot_of(int'(a[19:6]));
    tg = int'(a[31:20]);
    h  = 1'b0;
    hw = 0;
    for (int i = 0; i < 8; i++)
      if (!h && m_st[s][i] != 0 && m_tag[s][i] == tg) begin
        h  = 1'b1;
        hw = i;
      end
    e_mv = !md && (c <= 4'd6);
    case (c)
      4'd0, 4'd2: begin
        e_reads++;
        if (h) begin
          e_hits++;
          touch(s, hw);
        end else begin
          e_misses++;
          e_bus = 3'd1;
          w = pick_victim(s);
          e_wb = (m_st[s][w] == 3);
          m_st[s][w]  = (a[1] == 1'b0) ? 1 : 2;
          m_tag[s][w] = tg;
          touch(s, w);
        end
      end
      4'd1: begin
        e_writes++;
        if (h) begin
          e_hits++;
          if (m_st[s][hw] == 1) e_bus = 3'd3;
          m_st[s][hw] = 3;
          touch(s, hw);
        end else begin
          e_misses++;
          e_bus = 3'd4;
          w = pick_victim(s);
          e_wb = (m_st[s][w] == 3);
          m_st[s][w]  = 3;
          m_tag[s][w] = tg;
          touch(s, w);
        end
      end
      4'd3: if (h) begin
        if (m_st[s][hw] == 3) begin e_snp = 2'd2; e_bus = 3'd2; end
        else e_snp = 2'd1;
        m_st[s][hw] = 1;
      end
      4'd5: if (h) begin
        if (m_st[s][hw] == 3) begin e_snp = 2'd2; e_bus = 3'd2; end
        else e_snp = 2'd1;
        m_st[s][hw] = 0;
      end
      4'd6: if (h && m_st[s][hw] == 1) begin
        e_snp = 2'd1;
        m_st[s][hw] = 0;
      end
      4'd8: begin
        model_clear();
        e_reads = '0; e_writes = '0; e_hits = '0; e_misses = '0;
      end
      default: ;
    endcase
  endtask

  // One clock of stimulus; returns just after the consuming edge
  task automatic step(input logic e, input logic [3:0] c, input logic [31:0] a, input logic md);
    @(negedge clk);
    #1;
    bus_if.eof     = e;
    bus_if.command = c;
    bus_if.address = a;
    bus_if.mode    = md;
    model_step(e, c, a, md);
    @(posedge clk);
    #1;
  endtask

  // Compare DUT against the model on every cycle
  always @(negedge clk) begin
    chk("reads",        bus_if.reads,        e_reads);
    chk("writes",       bus_if.writes,       e_writes);
    chk("cache_hits",   bus_if.cache_hits,   e_hits);
    chk("cache_misses", bus_if.cache_misses, e_misses);
    chk("msg_valid",    32'(bus_if.msg_valid), 32'(e_mv));
    if (e_mv) begin
      chk("bus_op",     32'(bus_if.bus_op),     32'(e_bus));
      chk("evict_wb",   32'(bus_if.evict_wb),   32'(e_wb));
      chk("snoop_resp", 32'(bus_if.snoop_resp), 32'(e_snp));
    end
  end

  initial begin
    int r, c, sl, tg, lo;
    logic md, e;
    rst = 1'b1;
    bus_if.eof = 1'b0; bus_if.command = '0; bus_if.address = '0; bus_if.mode = 1'b0;
    e_reads = '0; e_writes = '0; e_hits = '0; e_misses = '0;
    e_bus = '0; e_wb = 1'b0; e_snp = '0; e_mv = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_reads", bus_if.reads, 32'd0);
    chk("reset_msg_valid", 32'(bus_if.msg_valid), 32'd0);

    // Read miss then hit
    step(1, 4'd0, 32'h2, 0);
    chk("rd_miss_bus", 32'(bus_if.bus_op), 32'd1);
    chk("rd_miss_reads", bus_if.reads, 32'd1);
    chk("rd_miss_misses", bus_if.cache_misses, 32'd1);
    chk("model_line_E", 32'(m_st[0][0]), 32'd2);
    step(1, 4'd0, 32'h2, 0);
    chk("rd_hit_hits", bus_if.cache_hits, 32'd1);
    chk("rd_hit_bus", 32'(bus_if.bus_op), 32'd0);
    // Write path
    step(1, 4'd1, 32'h2, 0);
    chk("wr_E_bus", 32'(bus_if.bus_op), 32'd0);
    chk("wr_E_writes", bus_if.writes, 32'd1);
    chk("wr_E_hits", bus_if.cache_hits, 32'd2);
    step(1, 4'd3, 32'h2, 0);
    chk("snp_M_resp", 32'(bus_if.snoop_resp), 32'd2);
    chk("snp_M_bus", 32'(bus_if.bus_op), 32'd2);
    step(1, 4'd1, 32'h2, 0);
    chk("wr_S_bus", 32'(bus_if.bus_op), 32'd3);

    // Clear, then PLRU eviction in set 5
    step(1, 4'd8, 32'h0, 0);
    chk("clr_reads", bus_if.reads, 32'd0);
    chk("clr_hits", bus_if.cache_hits, 32'd0);
    chk("clr_msg_valid", 32'(bus_if.msg_valid), 32'd0);
    for (int t = 0; t < 9; t++) step(1, 4'd0, mk(t, 5, 2), 0);
    chk("evict_misses", bus_if.cache_misses, 32'd9);
    chk("evict_wb_clean", 32'(bus_if.evict_wb), 32'd0);
    chk("model_way0_tag8", 32'(m_tag[1][0]), 32'd8);
    step(1, 4'd1, mk(0, 5, 2), 0);
    chk("evicted_wr_bus", 32'(bus_if.bus_op), 32'd4);
    chk("evicted_wr_misses", bus_if.cache_misses, 32'd10);

    // Snoop invalidate on S and on M lines
    step(1, 4'd0, mk(1, 0, 0), 0);
    step(1, 4'd6, mk(1, 0, 0), 0);
    chk("inv_S_resp", 32'(bus_if.snoop_resp), 32'd1);
    step(1, 4'd0, mk(1, 0, 0), 0);
    chk("inv_S_reread_bus", 32'(bus_if.bus_op), 32'd1);
    chk("inv_S_reread_misses", bus_if.cache_misses, 32'd12);
    step(1, 4'd6, mk(0, 5, 2), 0);
    chk("inv_M_resp", 32'(bus_if.snoop_resp), 32'd0);
    chk("inv_M_valid", 32'(bus_if.msg_valid), 32'd1);
    step(1, 4'd1, mk(0, 5, 2), 0);
    chk("inv_M_still_hit", 32'(bus_if.bus_op), 32'd0);

    // Modified victim write-back in set 77
    for (int t = 20; t < 29; t++) step(1, 4'd1, mk(t, 77, 3), 0);
    chk("wb_evict", 32'(bus_if.evict_wb), 32'd1);
    chk("wb_bus", 32'(bus_if.bus_op), 32'd4);

    // Idle cycles and unused codes
    step(0, 4'd0, mk(2, 5, 0), 0);
    step(0, 4'd1, mk(3, 5, 0), 0);
    step(1, 4'd7, mk(4, 5, 0), 0);
    step(1, 4'd15, mk(4, 5, 0), 0);
    chk("idle_reads", bus_if.reads, 32'd11);
    chk("idle_writes", bus_if.writes, 32'd11);
    chk("idle_msg_valid", 32'(bus_if.msg_valid), 32'd0);

    // Silent mode replay of the first sequence
    step(1, 4'd8, 32'h0, 0);
    step(1, 4'd0, 32'h2, 1);
    step(1, 4'd0, 32'h2, 1);
    step(1, 4'd1, 32'h2, 1);
    step(1, 4'd3, 32'h2, 1);
    step(1, 4'd1, 32'h2, 1);
    chk("silent_reads", bus_if.reads, 32'd2);
    chk("silent_writes", bus_if.writes, 32'd2);
    chk("silent_hits", bus_if.cache_hits, 32'd3);
    chk("silent_misses", bus_if.cache_misses, 32'd1);
    chk("silent_msg_valid", 32'(bus_if.msg_valid), 32'd0);

    // Randomized traffic over four sets with more tags than ways
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      e = 1'b1;
      if      (r < 30) c = 0;
      else if (r < 50) c = 1;
      else if (r < 55) c = 2;
      else if (r < 65) c = 3;
      else if (r < 70) c = 4;
      else if (r < 80) c = 5;
      else if (r < 88) c = 6;
      else if (r < 90) c = 9;
      else if (r < 92) c = (r == 90) ? 7 : int'($urandom_range(10, 15));
      else if (r < 93) c = 8;
      else begin c = 0; e = 1'b0; end
      sl = $urandom_range(0, 3);
      tg = $urandom_range(0, 11);
      lo = $urandom_range(0, 63);
      md = ($urandom_range(0, 3) == 0);
      step(e, 4'(c), mk(tg, idx_of(sl), lo), md);
    end
    step(0, 4'd0, 32'h0, 0);
    step(0, 4'd0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
